lif_neuron_array: RTL

- Time-multiplexed array of N_NEURONS leaky integrate-and-fire neurons sharing one 2-stage update datapath.
- Per-neuron membrane voltage and refractory counter live in an internal register file.
- Parameters E_REST, TAU, V_TH, REFRAC and V_INIT are loaded over a config port.
- Sits between the TT pin adapter and the spike/voltage output mux; successor to the single-neuron LIF core, adding channels, refractory period, saturation and a valid/ready input stream.

---
 rtl/lif_pkg.sv | 34 +++
 rtl/lif_update_pipe.sv | 122 ++++++++++++
 rtl/lif_neuron_array.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the time-multiplexed LIF neuron array:
// config addresses, FSM state encodings, default Q format and saturating add.
package lif_pkg;

  localparam logic [2:0] CFG_E_REST = 3'd0;
  localparam logic [2:0] CFG_TAU    = 3'd1;
  localparam logic [2:0] CFG_V_TH   = 3'd2;
  localparam logic [2:0] CFG_REFRAC = 3'd3;
  localparam logic [2:0] CFG_V_INIT = 3'd4;

  typedef logic [1:0] state_t;
  localparam state_t S_CFG   = 2'd0;
  localparam state_t S_INIT  = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_DRAIN = 2'd3;

  localparam int LIF_DATA_W = 16;
  localparam int LIF_FRAC_W = 8;

  // Three-operand add clamped to the signed range of a w-bit word (w <= 30).
  function automatic logic signed [63:0] sat_add3(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input logic signed [63:0] c,
                                                  input int w);
    logic signed [63:0] s, hi, lo;
    s  = a + b + c;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/lif_update_pipe.sv
// Two-stage LIF update: leak multiply in stage 1, integrate/saturate/threshold
// in stage 2, with stage-2 results forwarded to a stage-1 read of the same neuron.
module lif_update_pipe
  import lif_pkg::*;
#(
  parameter int DATA_W   = LIF_DATA_W,
  parameter int FRAC_W   = LIF_FRAC_W,
  parameter int REFRAC_W = 4,
  parameter int IDX_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  input  logic [IDX_W-1:0]         i_idx,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic signed [DATA_W-1:0] i_rd_v,
  input  logic [REFRAC_W-1:0]      i_rd_ref,
  input  logic signed [DATA_W-1:0] i_e_rest,
  input  logic [DATA_W-1:0]        i_tau,
  input  logic signed [DATA_W-1:0] i_v_th,
  input  logic [REFRAC_W-1:0]      i_refrac,
  output logic                     o_wb_en,
  output logic [IDX_W-1:0]         o_wb_idx,
  output logic signed [DATA_W-1:0] o_wb_v,
  output logic [REFRAC_W-1:0]      o_wb_ref,
  output logic                     o_out_valid,
  output logic [IDX_W-1:0]         o_out_idx,
  output logic signed [DATA_W-1:0] o_out_v,
  output logic                     o_out_spike
);

  localparam int PW = 2 * DATA_W + 1;

  logic                     r_vld_p1;
  logic [IDX_W-1:0]         r_idx_p1;
  logic signed [PW-1:0]     r_s_p1;
  logic signed [DATA_W-1:0] r_data_p1;
  logic [REFRAC_W-1:0]      r_ref_p1;
  logic                     r_refr_p1;

  logic                     r_out_valid;
  logic [IDX_W-1:0]         r_out_idx;
  logic signed [DATA_W-1:0] r_out_v;
  logic                     r_out_spike;

  logic                     w_fwd;
  logic signed [DATA_W-1:0] w_v_s1;
  logic [REFRAC_W-1:0]      w_ref_s1;
  logic signed [DATA_W:0]   w_d;
  logic signed [PW-1:0]     w_d_x;
  logic signed [PW-1:0]     w_tau_x;
  logic signed [DATA_W-1:0] w_sum;
  logic signed [DATA_W-1:0] w_wb_v;
  logic [REFRAC_W-1:0]      w_wb_ref;
  logic signed [DATA_W-1:0] w_out_v;
  logic                     w_spike;

  // Stage 1: read (or forward) neuron state, compute leaked offset from rest
  assign w_fwd    = r_vld_p1 && (r_idx_p1 == i_idx);
  assign w_v_s1   = w_fwd ? w_wb_v   : i_rd_v;
  assign w_ref_s1 = w_fwd ? w_wb_ref : i_rd_ref;
  assign w_d      = (DATA_W+1)'(w_v_s1) - (DATA_W+1)'(i_e_rest);
  assign w_d_x    = PW'(w_d);
  assign w_tau_x  = PW'(i_tau);

  always_ff @(posedge clk) begin
    if (i_vld) begin
      r_idx_p1  <= i_idx;
      r_s_p1    <= (w_d_x * w_tau_x) >>> FRAC_W;
      r_data_p1 <= i_data;
      r_ref_p1  <= w_ref_s1;
      r_refr_p1 <= (w_ref_s1 != '0);
    end
  end

  // Stage 2: integrate, saturate, threshold and decide write-back
  assign w_sum = DATA_W'(sat_add3(64'(r_s_p1), 64'(i_e_rest), 64'(r_data_p1), DATA_W));

  always_comb begin
    w_wb_v   = w_sum;
    w_wb_ref = '0;
    w_out_v  = w_sum;
    w_spike  = 1'b0;
    if (r_refr_p1) begin
      w_wb_v   = i_e_rest;
      w_wb_ref = r_ref_p1 - REFRAC_W'(1);
      w_out_v  = i_e_rest;
    end else if (w_sum >= i_v_th) begin
      w_wb_v   = i_e_rest;
      w_wb_ref = i_refrac;
      w_spike  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_v     <= '0;
      r_out_spike <= 1'b0;
    end else begin
      r_vld_p1    <= i_vld;
      r_out_valid <= r_vld_p1;
      if (r_vld_p1) begin
        r_out_idx   <= r_idx_p1;
        r_out_v     <= w_out_v;
        r_out_spike <= w_spike;
      end
    end
  end

  assign o_wb_en     = r_vld_p1;
  assign o_wb_idx    = r_idx_p1;
  assign o_wb_v      = w_wb_v;
  assign o_wb_ref    = w_wb_ref;
  assign o_out_valid = r_out_valid;
  assign o_out_idx   = r_out_idx;
  assign o_out_v     = r_out_v;
  assign o_out_spike = r_out_spike;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of leaky integrate-and-fire neurons sharing one update pipeline.
// Optional per-neuron 8-bit spike counters when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int DATA_W    = LIF_DATA_W,
  parameter int FRAC_W    = LIF_FRAC_W,
  parameter int REFRAC_W  = 4,
  localparam int IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_addr,
  input  logic [DATA_W-1:0]        cfg_data,
  input  logic                     run,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic [IDX_W-1:0]         out_idx,
  output logic signed [DATA_W-1:0] out_v,
  output logic                     out_spike,
  output logic                     busy
`ifdef LIF_SPIKE_COUNT_EN
  ,
  input  logic [IDX_W-1:0]         cnt_sel,
  output logic [7:0]               cnt_out
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_drain;
  logic signed [DATA_W-1:0] r_e_rest;
  logic [DATA_W-1:0]        r_tau;
  logic signed [DATA_W-1:0] r_v_th;
  logic [REFRAC_W-1:0]      r_refrac;
  logic signed [DATA_W-1:0] r_v_init;
  logic signed [DATA_W-1:0] r_v   [DEPTH];
  logic [REFRAC_W-1:0]      r_ref [DEPTH];

  logic                     w_accept;
  logic                     w_last;
  logic                     w_wb_en;
  logic [IDX_W-1:0]         w_wb_idx;
  logic signed [DATA_W-1:0] w_wb_v;
  logic [REFRAC_W-1:0]      w_wb_ref;

  assign in_ready = (r_state == S_RUN);
  assign busy     = (r_state != S_CFG);
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx == IDX_W'(N_NEURONS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_CFG;
      r_idx    <= '0;
      r_drain  <= 1'b0;
      r_e_rest <= '0;
      r_tau    <= '0;
      r_v_th   <= '0;
      r_refrac <= '0;
      r_v_init <= '0;
    end else begin
      case (r_state)
        S_CFG: begin
          if (cfg_we) begin
            case (cfg_addr)
              CFG_E_REST: r_e_rest <= cfg_data;
              CFG_TAU:    r_tau    <= cfg_data;
              CFG_V_TH:   r_v_th   <= cfg_data;
              CFG_REFRAC: r_refrac <= cfg_data[REFRAC_W-1:0];
              CFG_V_INIT: r_v_init <= cfg_data;
              default: ;
            endcase
          end
          if (run) begin
            r_state <= S_INIT;
            r_idx   <= '0;
          end
        end
        S_INIT: begin
          if (w_last) begin
            r_state <= S_RUN;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_RUN: begin
          if (w_accept) r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
          if (!run) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end
        end
        default: begin
          r_drain <= 1'b1;
          if (r_drain) r_state <= S_CFG;
        end
      endcase
    end
  end

  // The pipeline is empty while S_INIT sweeps the register file
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_v[r_idx]   <= r_v_init;
      r_ref[r_idx] <= '0;
    end else if (w_wb_en && !rst) begin
      r_v[w_wb_idx]   <= w_wb_v;
      r_ref[w_wb_idx] <= w_wb_ref;
    end
  end

  lif_update_pipe #(
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .REFRAC_W(REFRAC_W),
    .IDX_W   (IDX_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_vld      (w_accept),
    .i_idx      (r_idx),
    .i_data     (in_data),
    .i_rd_v     (r_v[r_idx]),
    .i_rd_ref   (r_ref[r_idx]),
    .i_e_rest   (r_e_rest),
    .i_tau      (r_tau),
    .i_v_th     (r_v_th),
    .i_refrac   (r_refrac),
    .o_wb_en    (w_wb_en),
    .o_wb_idx   (w_wb_idx),
    .o_wb_v     (w_wb_v),
    .o_wb_ref   (w_wb_ref),
    .o_out_valid(out_valid),
    .o_out_idx  (out_idx),
    .o_out_v    (out_v),
    .o_out_spike(out_spike)
  );

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0] r_cnt [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || r_state == S_INIT) begin
      for (int k = 0; k < DEPTH; k++) r_cnt[k] <= '0;
    end else if (out_valid && out_spike && r_cnt[out_idx] != 8'hFF) begin
      r_cnt[out_idx] <= r_cnt[out_idx] + 8'd1;
    end
  end

  assign cnt_out = r_cnt[cnt_sel];
`endif

endmodule
